// File: rtl/slow_divn.sv
`default_nettype none
// ============================================================================
// Module   : slow_divn
// Purpose  : Iterative restoring divider. It produces one quotient bit per
//            clock, MSB first, and works on unsigned or two's-complement
//            operands. Divide-by-zero and signed overflow
//            (most-negative / -1) are reported with flags.
// Ports    : clk   - clock, rising edge
//            rst   - synchronous reset, active low
//            start - request pulse, sampled only in IDLE with no result strobe
//            sgn   - 0 = unsigned, 1 = two's-complement (sampled with start)
//            X, Y  - dividend / divisor (sampled with start)
//            busy  - a division is in progress (CALC or DONE)
//            valid - one-cycle result strobe
//            quot, rem, dbz, ovf - registered result, held until next result
// Revision : 1.0 - initial release
// ============================================================================
module slow_divn #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             dbz,
    output logic             ovf
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam int                 c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_MIN      = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic [WIDTH-1:0]   r_acc;      // partial remainder
    logic [WIDTH-1:0]   r_dvd;      // dividend magnitude, shifted out as quotient shifts in
    logic [WIDTH:0]     r_dvs;      // divisor magnitude
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_x;        // raw dividend, returned as remainder on divide-by-zero
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dbz;
    logic               r_ovf;

    logic               r_valid;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_rem;
    logic               r_dbz_o;
    logic               r_ovf_o;

    logic               w_accept;
    logic               w_y_zero;
    logic               w_x_neg;
    logic               w_y_neg;
    logic               w_ovf_case;
    logic [WIDTH:0]     w_x_mag;
    logic [WIDTH:0]     w_y_mag;
    logic [WIDTH:0]     w_shift;
    logic               w_fits;
    logic [WIDTH-1:0]   w_sub;
    logic [WIDTH-1:0]   w_acc_nxt;

    // A start coinciding with the result strobe is dropped; the next cycle
    // (IDLE, strobe low) accepts a new request.
    assign w_accept   = (r_state == c_ST_IDLE) && start && !r_valid;
    assign w_y_zero   = (Y == '0);
    assign w_x_neg    = sgn & X[WIDTH-1];
    assign w_y_neg    = sgn & Y[WIDTH-1];
    assign w_ovf_case = sgn && (X == c_MIN) && (Y == '1);

    // Magnitudes are formed from the sign-extended operand in WIDTH+1 bits,
    // so the most-negative value maps to 2^(WIDTH-1) without wrapping.
    assign w_x_mag = w_x_neg ? -{X[WIDTH-1], X} : {1'b0, X};
    assign w_y_mag = w_y_neg ? -{Y[WIDTH-1], Y} : {1'b0, Y};

    // One restoring step. The partial remainder is always below the divisor,
    // so after a successful subtract the difference fits in WIDTH bits and
    // the low WIDTH bits of the subtraction are exact.
    assign w_shift   = {r_acc, r_dvd[WIDTH-1]};
    assign w_fits    = (w_shift >= r_dvs);
    assign w_sub     = w_shift[WIDTH-1:0] - r_dvs[WIDTH-1:0];
    assign w_acc_nxt = w_fits ? w_sub : w_shift[WIDTH-1:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_y_zero ? c_ST_DONE : c_ST_CALC;
                end
            end
            c_ST_CALC: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (r_state != c_ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_x     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz_o <= 1'b0;
            r_ovf_o <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        // Bit WIDTH of the dividend magnitude is always zero; it
                        // seeds the partial remainder as the bits above the
                        // WIDTH iterated positions.
                        r_acc   <= {{(WIDTH-1){1'b0}}, w_x_mag[WIDTH]};
                        r_dvd   <= w_x_mag[WIDTH-1:0];
                        r_dvs   <= w_y_mag;
                        r_cnt   <= '0;
                        r_x     <= X;
                        r_neg_q <= w_x_neg ^ w_y_neg;
                        r_neg_r <= w_x_neg;
                        r_dbz   <= w_y_zero;
                        r_ovf   <= w_ovf_case;
                    end
                end
                c_ST_CALC: begin
                    r_acc <= w_acc_nxt;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_fits};
                    r_cnt <= r_cnt + 1'b1;
                end
                c_ST_DONE: begin
                    r_valid <= 1'b1;
                    if (r_dbz) begin
                        r_quot  <= '1;
                        r_rem   <= r_x;
                        r_dbz_o <= 1'b1;
                        r_ovf_o <= 1'b0;
                    end else begin
                        // For most-negative / -1 the magnitude quotient is
                        // 2^(WIDTH-1) with a positive sign, which reads back
                        // as the most-negative value; only the flag differs.
                        r_quot  <= r_neg_q ? -r_dvd : r_dvd;
                        r_rem   <= r_neg_r ? -r_acc : r_acc;
                        r_dbz_o <= 1'b0;
                        r_ovf_o <= r_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = r_valid;
    assign quot  = r_quot;
    assign rem   = r_rem;
    assign dbz   = r_dbz_o;
    assign ovf   = r_ovf_o;

endmodule
`default_nettype wire

// File: tb/tb_slow_divn.sv
`default_nettype none
// ============================================================================
// Module   : tb_slow_divn
// Purpose  : Self-checking bench for slow_divn. One WIDTH=4 instance (lane 4)
//            and four WIDTH=8 instances (lanes 0..3) share clock and reset.
//            Expected results come from a behavioural model, are queued per
//            lane when a request is driven and popped when valid appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slow_divn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       st4, sg4, b4, v4, z4, o4;
    logic [3:0] x4, y4, q4, r4;

    logic       st8 [4];
    logic       sg8 [4];
    logic       b8  [4];
    logic       v8  [4];
    logic       z8  [4];
    logic       o8  [4];
    logic [7:0] x8  [4];
    logic [7:0] y8  [4];
    logic [7:0] q8  [4];
    logic [7:0] r8  [4];

    slow_divn #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(st4), .sgn(sg4), .X(x4), .Y(y4),
        .busy(b4), .valid(v4), .quot(q4), .rem(r4), .dbz(z4), .ovf(o4)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        slow_divn #(.WIDTH(8)) u_dut8 (
            .clk(clk), .rst(rst), .start(st8[gi]), .sgn(sg8[gi]),
            .X(x8[gi]), .Y(y8[gi]), .busy(b8[gi]), .valid(v8[gi]),
            .quot(q8[gi]), .rem(r8[gi]), .dbz(z8[gi]), .ovf(o8[gi])
        );
    end

    typedef struct packed {
        logic        s;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dbz;
        logic        ovf;
        logic [31:0] lat;
    } exp_t;

    typedef struct packed {
        logic       busy;
        logic       valid;
        logic       dbz;
        logic       ovf;
        logic [7:0] q;
        logic [7:0] r;
    } obs_t;

    exp_t sb [5][$];

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on sign-interpreted operands.
    function automatic exp_t model(input int w, input logic s, input logic [7:0] x, input logic [7:0] y);
        exp_t   e;
        longint one = 1;
        longint m   = (one << w) - 1;
        longint h   = one << (w - 1);
        longint xv  = longint'(x) & m;
        longint yv  = longint'(y) & m;
        longint xs, ys, qq, rr;
        e = '0;
        e.s = s; e.x = x; e.y = y;
        if (yv == 0) begin
            qq = m; rr = xv; e.dbz = 1'b1; e.lat = 32'd1;
        end else begin
            e.lat = 32'(w + 1);
            if (s) begin
                xs = (xv >= h) ? xv - 2 * h : xv;
                ys = (yv >= h) ? yv - 2 * h : yv;
                if (xs == -h && ys == -1) begin
                    e.ovf = 1'b1; qq = xv; rr = 0;
                end else begin
                    qq = xs / ys; rr = xs % ys;
                end
            end else begin
                qq = xv / yv; rr = xv % yv;
            end
        end
        e.q = 8'(qq & m);
        e.r = 8'(rr & m);
        return e;
    endfunction

    task automatic drive(input int ln, input logic st, input logic s, input logic [7:0] x, input logic [7:0] y);
        if (ln == 4) begin
            st4 = st; sg4 = s; x4 = x[3:0]; y4 = y[3:0];
        end else begin
            st8[ln] = st; sg8[ln] = s; x8[ln] = x; y8[ln] = y;
        end
    endtask

    function automatic obs_t sample(input int ln);
        obs_t o;
        if (ln == 4) begin
            o.busy = b4; o.valid = v4; o.dbz = z4; o.ovf = o4;
            o.q = {4'h0, q4}; o.r = {4'h0, r4};
        end else begin
            o.busy = b8[ln]; o.valid = v8[ln]; o.dbz = z8[ln]; o.ovf = o8[ln];
            o.q = q8[ln]; o.r = r8[ln];
        end
        return o;
    endfunction

    task automatic drive_random(input int ln, input logic st);
        drive(ln, st, 1'($urandom), 8'($urandom), 8'($urandom));
    endtask

    // Queue the expectation and raise start; the next rising edge is edge 0.
    task automatic issue(input int ln, input logic s, input logic [7:0] x, input logic [7:0] y);
        sb[ln].push_back(model((ln == 4) ? 4 : 8, s, x, y));
        drive(ln, 1'b1, s, x, y);
    endtask

    // Runs from just before edge 0 until the valid cycle. Inputs are
    // scrambled after edge 0; with poke=1 start is also held high through
    // busy and the valid cycle, and must be ignored.
    task automatic collect(input int ln, input logic poke);
        obs_t  o;
        exp_t  e;
        string t;
        int    n   = 0;
        int    nb  = 0;
        logic  got = 1'b0;
        @(negedge clk);
        drive_random(ln, poke);
        while (!got && n < 40) begin
            o = sample(ln);
            if (o.valid) begin
                got = 1'b1;
            end else begin
                if (o.busy) nb++;
                @(negedge clk);
                if (poke) drive_random(ln, 1'b1);
                n++;
            end
        end
        e = sb[ln].pop_front();
        t = $sformatf("L%0d s=%0b x=%0h y=%0h", ln, e.s, e.x, e.y);
        check({t, " latency"}, 32'(n), e.lat);
        if (got) begin
            check({t, " quot"}, {24'h0, o.q}, {24'h0, e.q});
            check({t, " rem"},  {24'h0, o.r}, {24'h0, e.r});
            check({t, " dbz"},  {31'h0, o.dbz}, {31'h0, e.dbz});
            check({t, " ovf"},  {31'h0, o.ovf}, {31'h0, e.ovf});
            check({t, " busy_cycles"}, 32'(nb), e.lat);
            check({t, " busy_at_valid"}, {31'h0, o.busy}, 32'h0);
        end
        if (poke) begin
            @(negedge clk);
            o = sample(ln);
            check({t, " start_in_valid_ignored_busy"}, {31'h0, o.busy}, 32'h0);
            check({t, " valid_one_cycle"}, {31'h0, o.valid}, 32'h0);
            drive(ln, 1'b0, 1'b0, 8'h00, 8'h00);
        end
    endtask

    task automatic run_op(input int ln, input logic s, input logic [7:0] x, input logic [7:0] y, input logic poke);
        obs_t o;
        @(negedge clk);
        o = sample(ln);
        check($sformatf("L%0d idle_valid", ln), {31'h0, o.valid}, 32'h0);
        check($sformatf("L%0d idle_busy", ln),  {31'h0, o.busy},  32'h0);
        issue(ln, s, x, y);
        collect(ln, poke);
    endtask

    task automatic lane_sweep(input int ln, input int count);
        logic [7:0] x, y;
        for (int i = 0; i < count; i++) begin
            x = ($urandom_range(0, 15) == 0) ? 8'h80 : 8'($urandom);
            case ($urandom_range(0, 15))
                0:       y = 8'h00;
                1:       y = 8'hFF;
                default: y = 8'($urandom);
            endcase
            run_op(ln, 1'($urandom), x, y, 1'b0);
        end
    endtask

    task automatic check_reset_outputs(input int ln, input string tag);
        obs_t o;
        o = sample(ln);
        check({tag, " busy"},  {31'h0, o.busy},  32'h0);
        check({tag, " valid"}, {31'h0, o.valid}, 32'h0);
        check({tag, " quot"},  {24'h0, o.q},     32'h0);
        check({tag, " rem"},   {24'h0, o.r},     32'h0);
        check({tag, " dbz"},   {31'h0, o.dbz},   32'h0);
        check({tag, " ovf"},   {31'h0, o.ovf},   32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int vcnt;
        rst = 1'b0;
        drive(4, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(negedge clk);

        // Start held high while reset is active must wait for the first
        // edge with reset released.
        issue(1, 1'b0, 8'd100, 8'd10);
        @(negedge clk);
        check_reset_outputs(1, "reset_state L1");
        check_reset_outputs(4, "reset_state L4");
        rst = 1'b1;
        collect(1, 1'b0);

        // WIDTH=4 directed: basic, back-to-back, start held during busy.
        run_op(4, 1'b0, 8'd15, 8'd8, 1'b0);
        run_op(4, 1'b0, 8'd10, 8'd2, 1'b0);
        run_op(4, 1'b0, 8'd9,  8'd4, 1'b1);
        run_op(4, 1'b1, 8'h8,  8'hF, 1'b0);

        // WIDTH=8 directed: signed, overflow, divide-by-zero.
        run_op(0, 1'b1, 8'hF9, 8'h02, 1'b0);
        run_op(0, 1'b1, 8'h80, 8'hFF, 1'b0);
        run_op(0, 1'b0, 8'h5A, 8'h00, 1'b0);

        // Reset in the third CALC cycle aborts the division silently.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 8'd200, 8'd7);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs(0, "mid_calc_reset L0");
        rst = 1'b1;
        vcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (v8[0]) vcnt++;
        end
        check("mid_calc_reset no_valid", 32'(vcnt), 32'h0);
        run_op(0, 1'b0, 8'd200, 8'd7, 1'b0);

        // Sweep: WIDTH=4 exhaustive, WIDTH=8 random over four lanes.
        fork
            begin
                for (int s = 0; s < 2; s++)
                    for (int x = 0; x < 16; x++)
                        for (int y = 0; y < 16; y++)
                            run_op(4, 1'(s), 8'(x), 8'(y), 1'b0);
            end
            lane_sweep(0, 2500);
            lane_sweep(1, 2500);
            lane_sweep(2, 2500);
            lane_sweep(3, 2500);
        join

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/slow_divn.md
SLOW_DIVN -- requirements
Module: slow_divn

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8: operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  The block SHALL use this single clock and SHALL act on rising edges only.
REQ-003 rst  input  1  Reset SHALL be synchronous and active-low.
REQ-004 start  input  1  The block SHALL sample this request pulse in IDLE only.
REQ-005 sgn  input  1  The block SHALL sample this with start: 0 = unsigned operands, 1 = two's-complement operands.
REQ-006 X  input  WIDTH  The block SHALL take the dividend from this port, sampled with start.
REQ-007 Y  input  WIDTH  The block SHALL take the divisor from this port, sampled with start.
REQ-008 busy  output  1  The block SHALL drive this high while a division is in progress.
REQ-009 valid  output  1  The block SHALL drive this as a one-cycle result strobe.
REQ-010 quot  output  WIDTH  The block SHALL drive the quotient here; it is registered and held until the next result.
REQ-011 rem  output  WIDTH  The block SHALL drive the remainder here; it is registered and held until the next result.
REQ-012 dbz  output  1  The block SHALL use this flag for divide-by-zero; it is held with the result.
REQ-013 ovf  output  1  The block SHALL use this flag for signed overflow; it is held with the result.

Function
REQ-014 The state machine SHALL have states IDLE, CALC and DONE; reset SHALL enter IDLE.
REQ-015 IDLE: on an edge with start=1, the block SHALL latch X, Y and sgn, SHALL set busy=1, and SHALL go to CALC (or DONE when Y=0).
REQ-016 CALC SHALL perform restoring division on operand magnitudes, producing one quotient bit per cycle, MSB first, for exactly WIDTH cycles, then go to DONE.
REQ-017 DONE SHALL last one cycle: valid=1, quot, rem, dbz and ovf updated; busy SHALL drop on the same edge that valid rises; next state SHALL be IDLE.
REQ-018 Latency SHALL be as follows: with start sampled at edge 0, valid SHALL be high in the cycle after edge WIDTH+1, for nonzero Y.
REQ-019 A start that is high while busy=1 or valid=1 SHALL be ignored; the in-flight operands SHALL remain unchanged.
REQ-020 Unsigned mode SHALL produce quot = floor(X/Y) and rem = X - quot*Y, where 0 <= rem < Y.
REQ-021 In signed mode, the quotient SHALL truncate toward zero, rem SHALL take the sign of X, and |rem| < |Y|.
REQ-022 Magnitude of the most-negative value SHALL be handled in WIDTH+1 bits internally with no loss.
REQ-023 For Y=0, valid SHALL be asserted after edge 1 (no CALC), with dbz=1, quot=all ones, rem=X, ovf=0.
REQ-024 For signed X = most-negative and Y = -1, the block SHALL produce ovf=1, quot = most-negative, rem=0, dbz=0, at normal latency.
REQ-025 In all other cases, dbz and ovf SHALL be 0.
REQ-026 valid SHALL stay low in every cycle except the single DONE cycle.
REQ-027 A start arriving in the cycle after valid (block back in IDLE) SHALL be accepted.
REQ-028 Changes on X, Y and sgn after the start edge SHALL have no effect on the current result.

Reset
REQ-029 While rst=0 at a rising edge, the block SHALL set the state to IDLE and busy, valid, quot, rem, dbz and ovf to 0, clearing internal registers.
REQ-030 Reset mid-CALC or mid-DONE SHALL abort the division, with no valid pulse and no partial result visible.
REQ-031 start SHALL be ignored on any edge where rst=0; the first start SHALL be accepted on the first edge with rst=1.

Verification
REQ-032 The bench SHALL apply WIDTH=4, unsigned, X=15, Y=8, start pulse -> valid one cycle after edge 5, quot=1, rem=7, busy high for 5 cycles.
REQ-033 The bench SHALL apply WIDTH=4, back-to-back: X=10, Y=2 started the cycle after valid -> quot=5, rem=0; a start held during busy -> ignored.
REQ-034 The bench SHALL apply WIDTH=8, signed, X=-7 (0xF9), Y=2 -> quot=-3 (0xFD), rem=-1 (0xFF); then X=-128, Y=-1 -> ovf=1, quot=0x80, rem=0.
REQ-035 The bench SHALL apply WIDTH=8, Y=0, X=0x5A -> valid after edge 1, dbz=1, quot=0xFF, rem=0x5A.
REQ-036 The bench SHALL drop rst to 0 during cycle 3 of CALC -> no valid; all outputs 0; a new start X=200, Y=7 -> quot=28, rem=4.
REQ-037 The bench SHALL run a random unsigned and signed sweep (WIDTH=4 exhaustive, WIDTH=8 at least 10k vectors) against a reference model, checking quot, rem, dbz, ovf and latency.
